// File: rtl/lstm_gate_mac_pkg.sv
// Shared LSTM definitions: Q8.8 widths, saturation limits, gate-MAC FSM states
// and the activation-stage input packet.
package lstm_gate_mac_pkg;

  localparam int LSTM_INPUT_BITS = 16;
  localparam int LSTM_FRAC_BITS  = 8;
  localparam int LSTM_ACC_BITS   = 40;

  localparam logic signed [LSTM_INPUT_BITS-1:0] Q_SAT_MAX = 16'sh7FFF;
  localparam logic signed [LSTM_INPUT_BITS-1:0] Q_SAT_MIN = 16'sh8000;

  typedef logic [1:0] mac_state_t;
  localparam mac_state_t ST_IDLE  = 2'd0;
  localparam mac_state_t ST_ACCUM = 2'd1;
  localparam mac_state_t ST_DRAIN = 2'd2;
  localparam mac_state_t ST_FINAL = 2'd3;

  typedef struct packed {
    logic [LSTM_INPUT_BITS-1:0] data;
  } act_in_pkt_t;

endpackage

// File: rtl/lstm_gate_mac_q_round_sat.sv
// Round-half-up and saturate a wide signed fixed-point value down to Q8.8.
// Purely combinational; also used by the cell-state update stage.
module q_round_sat
  import lstm_gate_mac_pkg::*;
#(
  parameter int IN_BITS   = LSTM_ACC_BITS,
  parameter int FRAC_BITS = LSTM_FRAC_BITS
) (
  input  logic signed [IN_BITS-1:0]         value,
  output logic        [LSTM_INPUT_BITS-1:0] result,
  output logic                              sat
);

  localparam logic signed [IN_BITS:0] HALF = (IN_BITS+1)'(2 ** (FRAC_BITS - 1));
  localparam logic signed [IN_BITS:0] HI   = (IN_BITS+1)'(Q_SAT_MAX);
  localparam logic signed [IN_BITS:0] LO   = (IN_BITS+1)'(Q_SAT_MIN);

  logic signed [IN_BITS:0] biased;
  logic signed [IN_BITS:0] rounded;

  // NOTE: every output gets a default before the if-chain so no latch is inferred.
  always_comb begin
    biased  = {value[IN_BITS-1], value} + HALF;
    rounded = biased >>> FRAC_BITS;
    result  = rounded[LSTM_INPUT_BITS-1:0];
    sat     = 1'b0;
    if (rounded > HI) begin
      result = Q_SAT_MAX;
      sat    = 1'b1;
    end else if (rounded < LO) begin
      result = Q_SAT_MIN;
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/lstm_gate_mac.sv
// LSTM gate pre-activation MAC: z = bias + sum(x*w) over a streamed Q8.8 vector,
// rounded and saturated back to Q8.8 with a one-cycle result strobe.
module lstm_gate_mac
  import lstm_gate_mac_pkg::*;
#(
  parameter int DATA_BITS = LSTM_INPUT_BITS,
  parameter int FRAC_BITS = LSTM_FRAC_BITS,
  parameter int ACC_BITS  = LSTM_ACC_BITS,
  parameter int MAX_LEN   = 256,
  parameter int CNT_BITS  = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] x_data,
  input  logic [DATA_BITS-1:0] w_data,
  input  logic                 in_last,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_sat,
  output logic                 busy,
  output logic [CNT_BITS-1:0]  beat_cnt
);

  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(MAX_LEN - 1);

  mac_state_t                     state;
  logic signed [ACC_BITS-1:0]     acc;
  logic signed [2*DATA_BITS-1:0]  prod_q;
  logic                           prod_v;
  act_in_pkt_t                    out_pkt;
  logic [DATA_BITS-1:0]           rnd_data;
  logic                           rnd_sat;
  logic                           beat;

  assign in_ready = (state == ST_ACCUM);
  assign busy     = (state != ST_IDLE);
  assign beat     = in_valid && in_ready;
  assign out_data = out_pkt.data;

  q_round_sat #(
    .IN_BITS   (ACC_BITS),
    .FRAC_BITS (FRAC_BITS)
  ) u_round (
    .value  (acc),
    .result (rnd_data),
    .sat    (rnd_sat)
  );

  // NOTE: all state uses non-blocking assignments; later assignments in the block
  // (e.g. the IDLE bias load) deliberately override the default accumulate.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      acc       <= '0;
      prod_q    <= '0;
      prod_v    <= 1'b0;
      beat_cnt  <= '0;
      out_pkt   <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (prod_v) begin
        acc <= acc + {{(ACC_BITS-2*DATA_BITS){prod_q[2*DATA_BITS-1]}}, prod_q};
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc      <= {{(ACC_BITS-DATA_BITS-FRAC_BITS){bias[DATA_BITS-1]}}, bias, {FRAC_BITS{1'b0}}};
            beat_cnt <= '0;
            state    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          prod_v <= beat;
          if (beat) begin
            prod_q   <= $signed(x_data) * $signed(w_data);
            beat_cnt <= beat_cnt + CNT_BITS'(1);
            if (in_last || beat_cnt == LAST_CNT) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          prod_v <= 1'b0;
          state  <= ST_FINAL;
        end
        default: begin
          out_pkt.data <= rnd_data;
          out_sat      <= rnd_sat;
          out_valid    <= 1'b1;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_gate_mac.sv
// Directed bench for lstm_gate_mac, built with MAX_LEN=4 so the forced-last
// path is reachable with short vectors.
module tb_lstm_gate_mac;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_data;
  logic [15:0] w_data;
  logic        in_last;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sat;
  logic        busy;
  logic [2:0]  beat_cnt;

  int errors = 0;
  int checks = 0;

  logic [15:0] xv [8];
  logic [15:0] wv [8];
  bit          lv [8];
  int          gv [8];

  logic [15:0] res_data;
  logic        res_sat;
  int          res_lat;
  int          res_acc;
  logic [2:0]  res_cnt;
  logic [15:0] ref_data;
  int          seen;

  always #5 clock = ~clock;

  lstm_gate_mac #(
    .MAX_LEN  (4),
    .CNT_BITS (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_data    (x_data),
    .w_data    (w_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int i, input logic [15:0] x, input logic [15:0] w, input bit l, input int g);
    xv[i] = x;
    wv[i] = w;
    lv[i] = l;
    gv[i] = g;
  endtask

  // Starts a vector from the current cycle and returns in the out_valid cycle
  // (or after a bounded wait); res_lat counts cycles after the last accepted beat.
  task automatic send_vec(input logic [15:0] b, input int n, input bit poke);
    int since;
    since   = 0;
    res_acc = 0;
    bias    = b;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gv[i]; g++) begin
        in_valid = 1'b0;
        step();
        since++;
      end
      if (!in_ready) break;
      in_valid = 1'b1;
      x_data   = xv[i];
      w_data   = wv[i];
      in_last  = lv[i];
      if (poke && i == 1) begin
        start = 1'b1;
        bias  = 16'h7000;
      end
      step();
      start = 1'b0;
      res_acc++;
      since = 1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    while (!out_valid && since < 12) begin
      step();
      since++;
    end
    res_lat  = since;
    res_data = out_data;
    res_sat  = out_sat;
    res_cnt  = beat_cnt;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    bias     = '0;
    in_valid = 1'b0;
    x_data   = '0;
    w_data   = '0;
    in_last  = 1'b0;
    for (int i = 0; i < 8; i++) load(i, 16'h0000, 16'h0000, 1'b0, 0);
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_sat", 32'(out_sat), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_beat_cnt", 32'(beat_cnt), 0);
    reset = 1'b0;
    step();

    // Basic: 1.0 + 2.0*1.0 + 0.5*2.0 = 4.0
    load(0, 16'h0200, 16'h0100, 1'b0, 0);
    load(1, 16'h0080, 16'h0200, 1'b1, 0);
    send_vec(16'h0100, 2, 1'b0);
    check("basic_data", 32'(res_data), 32'h0400);
    check("basic_sat", 32'(res_sat), 0);
    check("basic_latency", 32'(res_lat), 3);
    check("basic_beat_cnt", 32'(res_cnt), 2);
    check("basic_idle_in_valid_cycle", 32'(busy), 0);
    step();
    check("basic_pulse_one_cycle", 32'(out_valid), 0);
    check("basic_data_held", 32'(out_data), 32'h0400);

    // Saturation, both directions; 4 beats also hits MAX_LEN
    for (int i = 0; i < 4; i++) load(i, 16'h7FFF, 16'h7FFF, i == 3, 0);
    send_vec(16'h0000, 4, 1'b0);
    check("satpos_data", 32'(res_data), 32'h7FFF);
    check("satpos_sat", 32'(res_sat), 1);
    for (int i = 0; i < 4; i++) load(i, 16'h8000, 16'h7FFF, i == 3, 0);
    send_vec(16'h0000, 4, 1'b0);
    check("satneg_data", 32'(res_data), 32'h8000);
    check("satneg_sat", 32'(res_sat), 1);

    // Rounding: +0.5 LSB up, just under down, -0.5 LSB to zero, just past -0.5 to -1
    load(0, 16'h0001, 16'h0080, 1'b1, 0);
    send_vec(16'h0000, 1, 1'b0);
    check("rnd_half_up", 32'(res_data), 32'h0001);
    check("rnd_half_up_sat", 32'(res_sat), 0);
    load(0, 16'h0001, 16'h007F, 1'b1, 0);
    send_vec(16'h0000, 1, 1'b0);
    check("rnd_below_half", 32'(res_data), 32'h0000);
    load(0, 16'hFFFF, 16'h0080, 1'b1, 0);
    send_vec(16'h0000, 1, 1'b0);
    check("rnd_neg_half", 32'(res_data), 32'h0000);
    load(0, 16'hFFFF, 16'h0081, 1'b1, 0);
    send_vec(16'h0000, 1, 1'b0);
    check("rnd_neg_past_half", 32'(res_data), 32'hFFFF);
    check("rnd_neg_sat", 32'(res_sat), 0);

    // Gap-free reference: -1.0 + 3.0 - 0.25 + 0x33/256 = 0x01F3
    load(0, 16'h0180, 16'h0200, 1'b0, 0);
    load(1, 16'hFF00, 16'h0040, 1'b0, 0);
    load(2, 16'h0033, 16'h0100, 1'b1, 0);
    send_vec(16'hFF00, 3, 1'b0);
    ref_data = res_data;
    check("nogap_data", 32'(res_data), 32'h01F3);

    // Back-to-back: start in the out_valid cycle; 0.5 + 3.0*-0.5 = -1.0
    load(0, 16'h0300, 16'hFF80, 1'b1, 0);
    send_vec(16'h0080, 1, 1'b0);
    check("b2b_data", 32'(res_data), 32'hFF00);
    check("b2b_latency", 32'(res_lat), 3);

    // Same vector as the gap-free run, with bubbles between beats
    load(0, 16'h0180, 16'h0200, 1'b0, 1);
    load(1, 16'hFF00, 16'h0040, 1'b0, 2);
    load(2, 16'h0033, 16'h0100, 1'b1, 3);
    send_vec(16'hFF00, 3, 1'b0);
    check("gap_data", 32'(res_data), 32'h01F3);
    check("gap_matches_nogap", 32'(res_data), 32'(ref_data));
    check("gap_latency", 32'(res_lat), 3);

    // Forced last: six beats offered, last never set; 1+2+3+4 = 10.0
    for (int i = 0; i < 6; i++) load(i, 16'h0100, 16'((i + 1) << 8), 1'b0, 0);
    send_vec(16'h0000, 6, 1'b0);
    check("forced_accepted", 32'(res_acc), 4);
    check("forced_beat_cnt", 32'(res_cnt), 4);
    check("forced_data", 32'(res_data), 32'h0A00);
    check("forced_latency", 32'(res_lat), 3);

    // Start pulsed mid-vector with a different bias must be ignored: 2.0 + 1 + 1
    load(0, 16'h0100, 16'h0100, 1'b0, 0);
    load(1, 16'h0100, 16'h0100, 1'b0, 0);
    load(2, 16'h0000, 16'h0000, 1'b1, 0);
    send_vec(16'h0200, 3, 1'b1);
    check("ignstart_data", 32'(res_data), 32'h0400);
    check("ignstart_latency", 32'(res_lat), 3);
    step();
    check("ignstart_not_queued", 32'(busy), 0);

    // Reset after three beats of an in-flight vector
    bias  = 16'h0100;
    start = 1'b1;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    x_data   = 16'h0100;
    w_data   = 16'h0100;
    in_last  = 1'b0;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    check("midrst_beat_cnt_before", 32'(beat_cnt), 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_out_data", 32'(out_data), 0);
    check("midrst_out_sat", 32'(out_sat), 0);
    check("midrst_beat_cnt", 32'(beat_cnt), 0);
    check("midrst_busy", 32'(busy), 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      step();
    end
    check("midrst_no_out_valid", 32'(seen), 0);
    load(0, 16'h0100, 16'h0100, 1'b1, 0);
    send_vec(16'h0000, 1, 1'b0);
    check("postrst_data", 32'(res_data), 32'h0100);
    check("postrst_latency", 32'(res_lat), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lstm_gate_mac.md
Name: lstm_gate_mac

Overview:
- Upstream neighbour of the LSTM activation stages (sigmoid/tanh).
- Computes one gate pre-activation, z = b + sum(x_i * w_i), over a streamed vector of Q8.8 operand pairs.
- Rounds and saturates the result back to Q8.8.
- Presents the result with a one-cycle valid pulse; out_data drives the activation stage's input packet data field.

Parameters:
- DATA_BITS, 16, operand/result width (signed Q8.8; equals LSTM_INPUT_BITS)
- FRAC_BITS, 8, fractional bits of operands and result
- ACC_BITS, 40, signed accumulator width (Q24.16); no internal overflow for up to 256 full-scale terms
- MAX_LEN, 256, maximum beats per vector; the beat that reaches MAX_LEN is forced to be last
- CNT_BITS, 9, beat counter width (must satisfy 2^CNT_BITS > MAX_LEN)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a new vector, sampled only in IDLE
- bias  in  DATA_BITS  Q8.8 bias, sampled when start is accepted
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands; high only in ACCUM
- x_data  in  DATA_BITS  Q8.8 input/hidden element
- w_data  in  DATA_BITS  Q8.8 weight
- in_last  in  1  marks final beat of the vector
- out_valid  out  1  one-cycle result strobe
- out_data  out  DATA_BITS  Q8.8 saturated pre-activation; held until the next result
- out_sat  out  1  result was clipped; qualified by out_valid, held with out_data
- busy  out  1  high in ACCUM, DRAIN and FINAL
- beat_cnt  out  CNT_BITS  beats accepted in the current vector (debug)

Behaviour:
- Reset: state=IDLE; acc, prod_q, prod_v, beat_cnt, out_data, out_sat and out_valid all 0; in_ready=0. Reset mid-vector aborts and discards all partial state, with no out_valid.
- States: IDLE, ACCUM, DRAIN, FINAL.
- IDLE:
  - start=1 sets acc = sext(bias) << FRAC_BITS and beat_cnt=0, then moves to ACCUM.
  - start in any other state is ignored (no queuing).
- ACCUM:
  - in_ready=1; a beat is accepted when in_valid && in_ready.
  - On a beat: prod_q <= signed x_data*w_data (2*DATA_BITS, Q16.16), prod_v <= 1, beat_cnt++.
  - Each cycle with prod_v=1: acc <= acc + sext(prod_q).
  - in_valid gaps (bubbles) do not affect the result.
  - Accepted beat with in_last=1, or with beat_cnt+1 == MAX_LEN: move to DRAIN.
- DRAIN: in_ready=0; the final product is added into acc; prod_v cleared; move to FINAL.
- FINAL:
  - r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, i.e. arithmetic shift with round-half-up, so -0.5 LSB rounds to 0.
  - r > 32767 gives 0x7FFF; r < -32768 gives 0x8000; out_sat=1 when clipped.
  - Register out_data and out_sat, pulse out_valid, move to IDLE.
- Latency: if the last beat is accepted in cycle k, out_valid=1 in cycle k+3 for exactly one cycle.
- Back-to-back vectors: start may be asserted in the same cycle out_valid is high (the block is already in IDLE), giving a 1-cycle minimum gap between vectors.
- Empty vector: not possible; at least one beat is required.
- No backpressure on the output; the consumer must accept every out_valid.

Decomposition:
- Shared LSTM package: LSTM_INPUT_BITS, LSTM_FRAC_BITS, ACC_BITS, the Q8.8 saturation limits, and the gate-MAC FSM state enum.
- The output maps directly onto the existing activation input packet typedef (data field).
- One natural sub-module: q_round_sat (combinational round-half-up plus saturate, ACC_BITS down to DATA_BITS, with a sat flag). It is reusable by the cell-state update stage.

Test Plan:
- Basic: bias=0x0100, beats (x=0x0200, w=0x0100), (x=0x0080, w=0x0200, last) -> out_data=0x0400, out_sat=0, out_valid exactly at k+3.
- Saturation: bias=0, 4 beats of x=0x7FFF, w=0x7FFF -> 0x7FFF with out_sat=1; 4 beats of x=0x8000, w=0x7FFF -> 0x8000 with out_sat=1.
- Rounding: single beat x=0x0001, w=0x0080 -> 0x0001; x=0x0001, w=0x007F -> 0x0000; x=0xFFFF, w=0x0080 -> 0x0000; x=0xFFFF, w=0x0081 -> 0xFFFF.
- Bubbles and back-to-back: random in_valid gaps give the same result as the gap-free run; start asserted in the out_valid cycle is accepted and the second vector is correct.
- Forced last: MAX_LEN=4, six beats offered with in_last never set -> only 4 beats accepted (in_ready drops), beat_cnt=4, result equals the 4-term sum.
- Reset and ignored start: reset asserted in ACCUM after 3 beats -> no out_valid, outputs zero, next vector unpolluted; start pulsed while busy -> ignored, in-flight result unchanged.
